usb_tx_scheduler: RTL and testbench
===================================

# usb_tx_scheduler

Arbitrating sequencer in front of `USB_tx_top_level`. It accepts complete packets from two requesters: the miner's 256-bit hash results and short 2-word host responses. It latches the winning packet, starts the TX block with the correct strobe and header word, and feeds payload words on each `read_enable` edge. It then waits for end-of-packet (EOP), or aborts on `tx_error` or timeout, before granting the next packet.

## Interface
Parameters:
- `KICK_CYCLES`, 2: cycles the start strobe and header are held.
- `TIMEOUT`, 4096: max cycles waiting for a `read_enable` edge or EOP before abort.
- `HASH_HDR`, 16'h54D2: header word for hash packets.

Ports:
- `clk`  in  1  system clock
- `n_rst`  in  1  reset; asynchronous, active-low
- `hash_valid`  in  1  hash request
- `hash_data`  in  256  hash, MSW (`[255:240]`) sent first
- `hash_ready`  out  1  one-cycle accept pulse
- `pkt_valid`  in  1  short-packet request
- `pkt_hdr`  in  16  header word for the short packet
- `pkt_data`  in  32  payload, `[31:16]` sent first
- `pkt_ready`  out  1  one-cycle accept pulse
- `tx_data`  out  16  word presented to the TX block
- `transmit_start`  out  1  hash-packet kick strobe
- `transmit_empty`  out  1  short-packet kick strobe
- `read_enable`  in  1  TX word request (level; edge detected here)
- `tx_eop`  in  1  high while the line is in SE0 (`!d_plus && !d_minus`)
- `tx_error`  in  1  TX error
- `done`  out  1  one-cycle completion pulse
- `done_src`  out  1  source of the completed packet: 0 = short, 1 = hash; valid with `done`
- `done_err`  out  1  packet aborted (error or timeout); valid with `done`

## Operation
- States: IDLE, KICK, FEED, WAIT_EOP.
- IDLE:
  - If only one request is valid, grant it.
  - If both are valid, grant round-robin. The pointer starts at short after reset and flips after every grant.
  - On grant, pulse the matching `*_ready` for one cycle and latch the payload into a 256-bit shift buffer.
  - Set word count: 16 for hash, 2 for short.
  - Load `tx_data` with `HASH_HDR` (hash) or `pkt_hdr` (short). Go to KICK.
- KICK:
  - Assert `transmit_start` (hash) or `transmit_empty` (short) for exactly `KICK_CYCLES` cycles, then deassert.
  - Hold `tx_data` at the header. Go to FEED.
- FEED:
  - On each `read_enable` rising edge, drive `tx_data` with the next buffered word (MSW first), shift the buffer and decrement the count.
  - When the count reaches 0, go to WAIT_EOP. `tx_data` keeps the last word.
- WAIT_EOP:
  - On a rising edge of `tx_eop`, pulse `done` with `done_err=0` and return to IDLE.
  - Further `read_enable` edges here are ignored.
- Abort (KICK, FEED, WAIT_EOP):
  - `tx_error` high, or the timeout counter reaching `TIMEOUT`, triggers an abort.
  - Abort: pulse `done` with `done_err=1`, clear strobes, return to IDLE. The packet is dropped, not retried.
- Timeout counter: cleared on entry to FEED and on every `read_enable` edge; counts in FEED and WAIT_EOP.
- `done_src` reflects the latched grant.
- Requesters hold `*_valid` and data until their `*_ready` pulse; data is sampled only in the grant cycle.
- Reset mid-packet: everything returns to IDLE immediately. No `done` is produced.

## Timing
- Reset values:
  - `tx_data`=0, all strobes 0, `hash_ready`/`pkt_ready`=0, `done`/`done_src`/`done_err`=0.
  - State IDLE, round-robin pointer = short, edge-detect registers = 0.
- Grant: `*_ready` is registered, high the cycle after `*_valid` is sampled in IDLE. The strobe rises in the same cycle.
- Strobe is high for exactly `KICK_CYCLES` cycles.
- Word update: `tx_data` changes one cycle after the clock at which `read_enable` is sampled rising (registered edge detect). Word N is therefore stable before TX reads it at edge N+1.
- A `read_enable` edge in the same cycle as `tx_error`: the abort wins and no word advance occurs.
- `done` is registered: one cycle after the `tx_eop` rising edge or the abort condition.
- Earliest next grant is the cycle after `done`.
- Back-to-back packets: at least 1 IDLE cycle between `done` and the next strobe.

## Structure
- Shared package `usb_tx_pkg`:
  - state enum `sched_state_t`
  - `HASH_HDR`
  - word-count constants `HASH_WORDS`=16, `PKT_WORDS`=2
- Single module. No sub-module is required.
- Optional: a small `edge_detect` (rising) instance, reused for `read_enable` and `tx_eop`.

## Test plan
- Short only: `pkt_hdr`=16'h54C3, `pkt_data`=32'h23456789, with a TX model.
  - `pkt_ready` pulses; `transmit_empty` is high 2 cycles with `tx_data`=54C3.
  - Then `tx_data` is 2345, then 6789, on successive `read_enable` edges.
  - `tx_eop` gives `done`=1, `done_src`=0, `done_err`=0.
- Hash only: 256'h...80b66c91...f1a9f090.
  - `transmit_start` is high 2 cycles with `tx_data`=54D2.
  - The 16 words follow in order: first 0000, last f090.
  - `done_src`=1.
- Simultaneous `hash_valid` and `pkt_valid` out of reset:
  - Short is granted first, hash next.
  - Repeat: order alternates.
- `tx_error` asserted after the 5th hash word:
  - `done`=1 with `done_err`=1.
  - Strobes are 0; the state returns to IDLE; the next request is served normally.
- `TIMEOUT`=16 and no `read_enable` after the kick:
  - `done_err` pulses 16-17 cycles after FEED entry.
- `n_rst` asserted mid-FEED:
  - All outputs go to 0 asynchronously and no `done` is produced.
  - After release, a new short packet completes correctly.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX packet scheduler.
package usb_tx_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned BUF_W      = 256;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned HASH_WORDS = 16;
  localparam int unsigned PKT_WORDS  = 2;

  localparam logic [WORD_W-1:0] HASH_HDR = 16'h54D2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    KICK     = 2'd1,
    FEED     = 2'd2,
    WAIT_EOP = 2'd3
  } sched_state_t;

  // Everything latched from the winning requester in the grant cycle
  typedef struct packed {
    logic              is_hash;
    logic [WORD_W-1:0] hdr;
    logic [CNT_W-1:0]  words;
    logic [BUF_W-1:0]  payload;
  } grant_t;

endpackage

// File: rtl/usb_tx_scheduler_edge_detect.sv
// Rising-edge detector with one input register stage; rise_c is high for one cycle.
module usb_tx_scheduler_edge_detect (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic rise_c
);

  logic d_q;
  logic d_qq;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      d_q  <= 1'b0;
      d_qq <= 1'b0;
    end else begin
      d_q  <= d;
      d_qq <= d_q;
    end
  end

  assign rise_c = d_q & ~d_qq;

endmodule

// File: rtl/usb_tx_scheduler.sv
// Arbitrates hash results and short host responses, kicks the USB TX block
// and feeds it payload words on read_enable edges until EOP, error or timeout.
module usb_tx_scheduler #(
  parameter int unsigned KICK_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 4096,
  parameter logic [15:0] HASH_HDR    = usb_tx_pkg::HASH_HDR
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         hash_valid,
  input  logic [255:0] hash_data,
  output logic         hash_ready,
  input  logic         pkt_valid,
  input  logic [15:0]  pkt_hdr,
  input  logic [31:0]  pkt_data,
  output logic         pkt_ready,
  output logic [15:0]  tx_data,
  output logic         transmit_start,
  output logic         transmit_empty,
  input  logic         read_enable,
  input  logic         tx_eop,
  input  logic         tx_error,
  output logic         done,
  output logic         done_src,
  output logic         done_err
);

  import usb_tx_pkg::*;

  localparam int unsigned KC_W = (KICK_CYCLES > 1) ? $clog2(KICK_CYCLES) : 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  sched_state_t      state_q, state_d;
  grant_t            grant_c;
  logic              re_rise_c, eop_rise_c, abort_c, last_kick_c, pick_hash_c;
  logic              rr_hash_q, rr_hash_d;
  logic              src_hash_q, src_hash_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic [KC_W-1:0]   kick_q, kick_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [WORD_W-1:0] tx_data_d;
  logic              start_d, empty_d, hash_ready_d, pkt_ready_d;
  logic              done_d, done_src_d, done_err_d;

  usb_tx_scheduler_edge_detect u_re_edge (
    .clk    (clk),
    .n_rst  (n_rst),
    .d      (read_enable),
    .rise_c (re_rise_c)
  );

  usb_tx_scheduler_edge_detect u_eop_edge (
    .clk    (clk),
    .n_rst  (n_rst),
    .d      (tx_eop),
    .rise_c (eop_rise_c)
  );

  // Round-robin pick only matters when both requesters are valid
  assign pick_hash_c = hash_valid && (!pkt_valid || rr_hash_q);

  always_comb begin
    grant_c.is_hash = pick_hash_c;
    grant_c.hdr     = pkt_hdr;
    grant_c.words   = CNT_W'(PKT_WORDS);
    grant_c.payload = {pkt_data, {(BUF_W - 32){1'b0}}};
    if (pick_hash_c) begin
      grant_c.hdr     = HASH_HDR;
      grant_c.words   = CNT_W'(HASH_WORDS);
      grant_c.payload = hash_data;
    end
  end

  assign abort_c = (state_q != IDLE) &&
                   (tx_error || (((state_q == FEED) || (state_q == WAIT_EOP)) &&
                                 (to_q == TO_W'(TIMEOUT))));
  assign last_kick_c = (kick_q == KC_W'(KICK_CYCLES - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (hash_valid || pkt_valid) state_d = KICK;
      KICK:     if (abort_c) state_d = IDLE;
                else if (last_kick_c) state_d = FEED;
      FEED:     if (abort_c) state_d = IDLE;
                else if (re_rise_c && (words_q == CNT_W'(1))) state_d = WAIT_EOP;
      WAIT_EOP: if (abort_c || eop_rise_c) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values for the datapath and the registered outputs
  always_comb begin
    tx_data_d    = tx_data;
    start_d      = transmit_start;
    empty_d      = transmit_empty;
    hash_ready_d = 1'b0;
    pkt_ready_d  = 1'b0;
    done_d       = 1'b0;
    done_src_d   = done_src;
    done_err_d   = done_err;
    rr_hash_d    = rr_hash_q;
    src_hash_d   = src_hash_q;
    buf_d        = buf_q;
    words_d      = words_q;
    kick_d       = kick_q;
    to_d         = to_q;

    if (re_rise_c) to_d = '0;
    else if ((state_q == FEED) || (state_q == WAIT_EOP)) to_d = to_q + TO_W'(1);

    if (abort_c) begin
      start_d    = 1'b0;
      empty_d    = 1'b0;
      done_d     = 1'b1;
      done_err_d = 1'b1;
      done_src_d = src_hash_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (hash_valid || pkt_valid) begin
            hash_ready_d = grant_c.is_hash;
            pkt_ready_d  = !grant_c.is_hash;
            start_d      = grant_c.is_hash;
            empty_d      = !grant_c.is_hash;
            src_hash_d   = grant_c.is_hash;
            rr_hash_d    = !rr_hash_q;
            tx_data_d    = grant_c.hdr;
            buf_d        = grant_c.payload;
            words_d      = grant_c.words;
            kick_d       = '0;
          end
        end
        KICK: begin
          if (last_kick_c) begin
            start_d = 1'b0;
            empty_d = 1'b0;
            to_d    = '0;
          end else begin
            kick_d = kick_q + KC_W'(1);
          end
        end
        FEED: begin
          if (re_rise_c) begin
            tx_data_d = buf_q[BUF_W-1 -: WORD_W];
            buf_d     = {buf_q[BUF_W-WORD_W-1:0], WORD_W'(0)};
            words_d   = words_q - CNT_W'(1);
          end
        end
        WAIT_EOP: begin
          if (eop_rise_c) begin
            done_d     = 1'b1;
            done_err_d = 1'b0;
            done_src_d = src_hash_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_data        <= '0;
      transmit_start <= 1'b0;
      transmit_empty <= 1'b0;
      hash_ready     <= 1'b0;
      pkt_ready      <= 1'b0;
      done           <= 1'b0;
      done_src       <= 1'b0;
      done_err       <= 1'b0;
      rr_hash_q      <= 1'b0;
      src_hash_q     <= 1'b0;
      buf_q          <= '0;
      words_q        <= '0;
      kick_q         <= '0;
      to_q           <= '0;
    end else begin
      tx_data        <= tx_data_d;
      transmit_start <= start_d;
      transmit_empty <= empty_d;
      hash_ready     <= hash_ready_d;
      pkt_ready      <= pkt_ready_d;
      done           <= done_d;
      done_src       <= done_src_d;
      done_err       <= done_err_d;
      rr_hash_q      <= rr_hash_d;
      src_hash_q     <= src_hash_d;
      buf_q          <= buf_d;
      words_q        <= words_d;
      kick_q         <= kick_d;
      to_q           <= to_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Scoreboard bench for usb_tx_scheduler: a TX model pops expected words and
// completion flags as the DUT presents them.
module tb_usb_tx_scheduler;

  localparam logic [15:0]  HDR_HASH = 16'h54D2;
  localparam logic [255:0] HASH1 =
    256'h0000_1111_2222_3333_80b6_6c91_4444_5555_6666_7777_8888_9999_aaaa_bbbb_f1a9_f090;

  logic         tb_clk = 1'b0;
  logic         n_rst;
  logic         hash_valid;
  logic [255:0] hash_data;
  logic         hash_ready;
  logic         pkt_valid;
  logic [15:0]  pkt_hdr;
  logic [31:0]  pkt_data;
  logic         pkt_ready;
  logic [15:0]  tx_data;
  logic         transmit_start;
  logic         transmit_empty;
  logic         read_enable;
  logic         tx_eop;
  logic         tx_error;
  logic         done;
  logic         done_src;
  logic         done_err;

  int          vectors     = 0;
  int          miscompares = 0;
  bit          rr_model    = 1'b0;
  logic [15:0] exp_words[$];
  logic [1:0]  exp_done[$];

  usb_tx_scheduler #(
    .KICK_CYCLES (2),
    .TIMEOUT     (16),
    .HASH_HDR    (HDR_HASH)
  ) dut (
    .clk            (tb_clk),
    .n_rst          (n_rst),
    .hash_valid     (hash_valid),
    .hash_data      (hash_data),
    .hash_ready     (hash_ready),
    .pkt_valid      (pkt_valid),
    .pkt_hdr        (pkt_hdr),
    .pkt_data       (pkt_data),
    .pkt_ready      (pkt_ready),
    .tx_data        (tx_data),
    .transmit_start (transmit_start),
    .transmit_empty (transmit_empty),
    .read_enable    (read_enable),
    .tx_eop         (tx_eop),
    .tx_error       (tx_error),
    .done           (done),
    .done_src       (done_src),
    .done_err       (done_err)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic apply_reset();
    n_rst = 1'b0;
    hash_valid = 1'b0; hash_data = '0;
    pkt_valid = 1'b0; pkt_hdr = '0; pkt_data = '0;
    read_enable = 1'b0; tx_eop = 1'b0; tx_error = 1'b0;
    repeat (3) @(negedge tb_clk);
    n_rst = 1'b1;
    rr_model = 1'b0;
    @(negedge tb_clk);
  endtask

  task automatic push_pkt(input bit is_hash, input logic [15:0] hdr,
                          input logic [255:0] payload, input bit err);
    int n = is_hash ? 16 : 2;
    exp_words.push_back(hdr);
    for (int i = 0; i < n; i++) exp_words.push_back(payload[255-16*i -: 16]);
    exp_done.push_back({is_hash, err});
  endtask

  // TX-side model: accept the kick, pull words, then end with EOP or an error
  task automatic tx_model(input bit is_hash, input int n_words, input int err_after);
    int waited, width;
    logic [15:0] w;
    logic [1:0]  d;
    waited = 0;
    while (!(transmit_start || transmit_empty) && waited < 20) begin
      @(negedge tb_clk); waited++;
    end
    vectors++;
    if (!(transmit_start || transmit_empty)) begin
      miscompares++;
      $display("FAIL kick_wait: no strobe after %0d cycles", waited);
      return;
    end
    vectors++;
    if ({transmit_start, transmit_empty, hash_ready, pkt_ready} !==
        {is_hash, !is_hash, is_hash, !is_hash}) begin
      miscompares++;
      $display("FAIL grant: start/empty/hrdy/prdy=%b want %b",
               {transmit_start, transmit_empty, hash_ready, pkt_ready},
               {is_hash, !is_hash, is_hash, !is_hash});
    end
    if (is_hash) hash_valid = 1'b0; else pkt_valid = 1'b0;
    rr_model = !rr_model;
    w = exp_words.pop_front();
    vectors++;
    if (tx_data !== w) begin
      miscompares++;
      $display("FAIL header: tx_data=%h want %h", tx_data, w);
    end
    width = 1;
    @(negedge tb_clk);
    vectors++;
    if ((hash_ready | pkt_ready) !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_pulse: ready still high in second cycle");
    end
    while ((transmit_start || transmit_empty) && width < 10) begin
      width++; @(negedge tb_clk);
    end
    vectors++;
    if (width != 2) begin
      miscompares++;
      $display("FAIL strobe_width: %0d cycles want 2", width);
    end
    for (int i = 0; i < n_words; i++) begin
      if (i == err_after) break;
      read_enable = 1'b1; repeat (2) @(negedge tb_clk);
      read_enable = 1'b0; repeat (2) @(negedge tb_clk);
      w = exp_words.pop_front();
      vectors++;
      if (tx_data !== w) begin
        miscompares++;
        $display("FAIL word%0d: tx_data=%h want %h", i, tx_data, w);
      end
    end
    if (err_after >= 0 && err_after < n_words) begin
      tx_error = 1'b1; @(negedge tb_clk); tx_error = 1'b0;
      for (int i = err_after; i < n_words; i++) w = exp_words.pop_front();
    end else begin
      tx_eop = 1'b1;
    end
    waited = 0;
    while (!done && waited < 20) begin
      @(negedge tb_clk); waited++;
    end
    tx_eop = 1'b0;
    d = exp_done.pop_front();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_wait: no done after %0d cycles", waited);
    end else if ({done_src, done_err} !== d) begin
      miscompares++;
      $display("FAIL done_flags: src/err=%b want %b", {done_src, done_err}, d);
    end
    vectors++;
    if ((transmit_start | transmit_empty) !== 1'b0) begin
      miscompares++;
      $display("FAIL strobes_at_done: start/empty=%b want 00", {transmit_start, transmit_empty});
    end
    @(negedge tb_clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: done=%b in following cycle want 0", done);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({tx_data, transmit_start, transmit_empty, hash_ready, pkt_ready,
         done, done_src, done_err} !== 23'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: tx_data=%h strobes=%b%b rdy=%b%b done=%b%b%b want all 0",
               tx_data, transmit_start, transmit_empty, hash_ready, pkt_ready,
               done, done_src, done_err);
    end
  endtask

  task automatic test_short();
    @(negedge tb_clk);
    pkt_hdr = 16'h54C3; pkt_data = 32'h23456789; pkt_valid = 1'b1;
    push_pkt(1'b0, 16'h54C3, {32'h23456789, 224'h0}, 1'b0);
    tx_model(1'b0, 2, -1);
  endtask

  task automatic test_hash();
    @(negedge tb_clk);
    hash_data = HASH1; hash_valid = 1'b1;
    push_pkt(1'b1, HDR_HASH, HASH1, 1'b0);
    tx_model(1'b1, 16, -1);
  endtask

  task automatic test_simultaneous();
    logic [255:0] h;
    logic [15:0]  ph;
    logic [31:0]  pd;
    bit           first;
    apply_reset();
    for (int rep = 0; rep < 3; rep++) begin
      if (rep == 2) begin
        // a lone short grant moves the pointer, so hash should win next
        @(negedge tb_clk);
        pd = $urandom; pkt_hdr = 16'h1234; pkt_data = pd; pkt_valid = 1'b1;
        push_pkt(1'b0, 16'h1234, {pd, 224'h0}, 1'b0);
        tx_model(1'b0, 2, -1);
      end
      h  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ph = 16'($urandom);
      pd = $urandom;
      @(negedge tb_clk);
      hash_data = h; pkt_hdr = ph; pkt_data = pd;
      hash_valid = 1'b1; pkt_valid = 1'b1;
      first = rr_model;
      if (first) begin
        push_pkt(1'b1, HDR_HASH, h, 1'b0);
        push_pkt(1'b0, ph, {pd, 224'h0}, 1'b0);
      end else begin
        push_pkt(1'b0, ph, {pd, 224'h0}, 1'b0);
        push_pkt(1'b1, HDR_HASH, h, 1'b0);
      end
      tx_model(first, first ? 16 : 2, -1);
      tx_model(!first, first ? 2 : 16, -1);
    end
  endtask

  task automatic test_error();
    logic [255:0] h;
    h = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    @(negedge tb_clk);
    hash_data = h; hash_valid = 1'b1;
    push_pkt(1'b1, HDR_HASH, h, 1'b1);
    tx_model(1'b1, 16, 5);
    @(negedge tb_clk);
    pkt_hdr = 16'h5A5A; pkt_data = 32'h0BAD_F00D; pkt_valid = 1'b1;
    push_pkt(1'b0, 16'h5A5A, {32'h0BADF00D, 224'h0}, 1'b0);
    tx_model(1'b0, 2, -1);
  endtask

  task automatic test_timeout();
    int waited, c;
    @(negedge tb_clk);
    pkt_hdr = 16'h0F0F; pkt_data = $urandom; pkt_valid = 1'b1;
    waited = 0;
    while (!transmit_empty && waited < 20) begin @(negedge tb_clk); waited++; end
    vectors++;
    if (tx_data !== 16'h0F0F) begin
      miscompares++;
      $display("FAIL timeout_hdr: tx_data=%h want 0f0f", tx_data);
    end
    pkt_valid = 1'b0;
    rr_model = !rr_model;
    while (transmit_empty && waited < 40) begin @(negedge tb_clk); waited++; end
    c = 0;
    while (!done && c < 40) begin @(negedge tb_clk); c++; end
    vectors++;
    if (!done || c < 16 || c > 17) begin
      miscompares++;
      $display("FAIL timeout_latency: done after %0d cycles want 16..17", c);
    end
    vectors++;
    if ({done_src, done_err} !== 2'b01) begin
      miscompares++;
      $display("FAIL timeout_flags: src/err=%b want 01", {done_src, done_err});
    end
    @(negedge tb_clk);
  endtask

  task automatic test_reset_mid_feed();
    int waited;
    bit seen_done;
    logic [15:0] w;
    @(negedge tb_clk);
    pkt_hdr = 16'hA5C3; pkt_data = 32'hCAFEF00D; pkt_valid = 1'b1;
    push_pkt(1'b0, 16'hA5C3, {32'hCAFEF00D, 224'h0}, 1'b0);
    waited = 0;
    while (!pkt_ready && waited < 20) begin @(negedge tb_clk); waited++; end
    pkt_valid = 1'b0;
    while ((transmit_empty || transmit_start) && waited < 40) begin @(negedge tb_clk); waited++; end
    read_enable = 1'b1; repeat (2) @(negedge tb_clk);
    read_enable = 1'b0; repeat (2) @(negedge tb_clk);
    w = exp_words[1];
    vectors++;
    if (tx_data !== w) begin
      miscompares++;
      $display("FAIL midfeed_word: tx_data=%h want %h", tx_data, w);
    end
    #2 n_rst = 1'b0;
    #1;
    vectors++;
    if ({tx_data, transmit_start, transmit_empty, hash_ready, pkt_ready,
         done, done_src, done_err} !== 23'h0) begin
      miscompares++;
      $display("FAIL async_reset: tx_data=%h strobes=%b%b done=%b want all 0",
               tx_data, transmit_start, transmit_empty, done);
    end
    seen_done = 1'b0;
    repeat (4) begin @(negedge tb_clk); if (done) seen_done = 1'b1; end
    vectors++;
    if (seen_done) begin
      miscompares++;
      $display("FAIL reset_done: done=1 seen during reset want 0");
    end
    exp_words.delete();
    exp_done.delete();
    rr_model = 1'b0;
    n_rst = 1'b1;
    @(negedge tb_clk);
    pkt_hdr = 16'h54C3; pkt_data = 32'h13579BDF; pkt_valid = 1'b1;
    push_pkt(1'b0, 16'h54C3, {32'h13579BDF, 224'h0}, 1'b0);
    tx_model(1'b0, 2, -1);
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_short();
    test_hash();
    test_simultaneous();
    test_error();
    test_timeout();
    test_reset_mid_feed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
